// File: rtl/shared_net_arbiter_pkg.sv
// Shared types and width helpers for the shared-net round-robin arbiter.
package shared_net_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Index/counter width that stays at least one bit for degenerate sizes.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_net_arbiter_if.sv
// Request/grant bundle between the requesters and the shared-net arbiter.
interface shared_net_arbiter_if #(
  parameter int N_REQ = 4
);
  import shared_net_arbiter_pkg::*;

  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] rel;
  logic [N_REQ-1:0] drv_en;
  logic             owner_vld;
  logic [IW-1:0]    owner_id;
  logic             turn;
  logic             timeout;

  modport master (
    input  req,
    input  rel,
    output drv_en,
    output owner_vld,
    output owner_id,
    output turn,
    output timeout
  );

  modport slave (
    output req,
    output rel,
    input  drv_en,
    input  owner_vld,
    input  owner_id,
    input  turn,
    input  timeout
  );

endinterface

// File: rtl/shared_net_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module shared_net_arbiter_rr_pick
  import shared_net_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic             any_o,
  output logic [IW-1:0]    idx_o
);

  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IW-1:0]      off;
  logic               found;
  logic [IW:0]        sum;

  // Rotating the doubled vector puts ptr at bit 0, so lowest set bit wins.
  assign dbl = {req_i, req_i};
  assign rot = N_REQ'(dbl >> ptr_i);
  assign any_o = |req_i;

  always_comb begin
    off   = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
  end

  always_comb begin
    sum = {1'b0, ptr_i} + {1'b0, off};
    if (sum >= (IW+1)'(N_REQ)) begin
      idx_o = IW'(sum - (IW+1)'(N_REQ));
    end else begin
      idx_o = IW'(sum);
    end
  end

endmodule

// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbiter for one shared tri-state/wired net, with hold limit
// and an all-released turnaround gap between owners.
module shared_net_arbiter
  import shared_net_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shared_net_arbiter_if.master arb_if
);

  localparam int IW = idx_w(N_REQ);
  localparam int HW = idx_w(MAX_HOLD);
  localparam int TW = idx_w(TURN_CYC);
  localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [TW-1:0] TURN_LAST = TW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  arb_state_e       state_q;
  logic [N_REQ-1:0] drv_en_q;
  logic             owner_vld_q;
  logic [IW-1:0]    owner_id_q;
  logic             turn_q;
  logic             timeout_q;
  logic [IW-1:0]    rr_ptr_q;
  logic [HW-1:0]    hold_cnt_q;
  logic [TW-1:0]    turn_cnt_q;

  logic [IW-1:0]    next_ptr;
  logic [IW-1:0]    pick_ptr;
  logic             pick_any;
  logic [IW-1:0]    pick_idx;
  logic [N_REQ-1:0] grant_oh;
  logic             own_req;
  logic             own_rel;
  logic             hit_limit;
  logic             own_exit;
  logic [HW-1:0]    hold_inc;
  logic [TW-1:0]    turn_inc;

  assign next_ptr = (owner_id_q == IW'(N_REQ - 1)) ? '0 : owner_id_q + 1'b1;

  // Back-to-back handover searches past the outgoing owner on the same edge.
  assign pick_ptr = (state_q == OWN) ? next_ptr : rr_ptr_q;

  shared_net_arbiter_rr_pick #(
    .N_REQ(N_REQ)
  ) u_rr_pick (
    .req_i (arb_if.req),
    .ptr_i (pick_ptr),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
    assign grant_oh[gi] = (pick_idx == IW'(gi));
  end

  assign own_req   = arb_if.req[owner_id_q];
  assign own_rel   = arb_if.rel[owner_id_q];
  assign hit_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign own_exit  = !own_req || own_rel || hit_limit;
  assign hold_inc  = (hold_cnt_q == {HW{1'b1}}) ? hold_cnt_q : hold_cnt_q + 1'b1;
  assign turn_inc  = (turn_cnt_q == {TW{1'b1}}) ? turn_cnt_q : turn_cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      drv_en_q    <= '0;
      owner_vld_q <= 1'b0;
      owner_id_q  <= '0;
      turn_q      <= 1'b0;
      timeout_q   <= 1'b0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      turn_cnt_q  <= '0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          turn_q <= 1'b0;
          if (pick_any) begin
            state_q     <= OWN;
            drv_en_q    <= grant_oh;
            owner_vld_q <= 1'b1;
            owner_id_q  <= pick_idx;
            hold_cnt_q  <= '0;
          end
        end

        OWN: begin
          if (own_exit) begin
            // A request drop or release wins over a coincident hold-limit hit.
            timeout_q <= hit_limit && own_req && !own_rel;
            rr_ptr_q  <= next_ptr;
            if (TURN_CYC > 0) begin
              state_q     <= TURN;
              drv_en_q    <= '0;
              owner_vld_q <= 1'b0;
              turn_q      <= 1'b1;
              turn_cnt_q  <= '0;
            end else if (pick_any) begin
              state_q     <= OWN;
              drv_en_q    <= grant_oh;
              owner_vld_q <= 1'b1;
              owner_id_q  <= pick_idx;
              hold_cnt_q  <= '0;
            end else begin
              state_q     <= IDLE;
              drv_en_q    <= '0;
              owner_vld_q <= 1'b0;
            end
          end else begin
            hold_cnt_q <= hold_inc;
          end
        end

        TURN: begin
          if (turn_cnt_q == TURN_LAST) begin
            turn_q <= 1'b0;
            if (pick_any) begin
              state_q     <= OWN;
              drv_en_q    <= grant_oh;
              owner_vld_q <= 1'b1;
              owner_id_q  <= pick_idx;
              hold_cnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            turn_cnt_q <= turn_inc;
          end
        end

        default: begin
          state_q     <= IDLE;
          drv_en_q    <= '0;
          owner_vld_q <= 1'b0;
          turn_q      <= 1'b0;
        end
      endcase
    end
  end

  assign arb_if.drv_en    = drv_en_q;
  assign arb_if.owner_vld = owner_vld_q;
  assign arb_if.owner_id  = owner_id_q;
  assign arb_if.turn      = turn_q;
  assign arb_if.timeout   = timeout_q;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Scoreboard bench: three arbiter configurations share one stimulus stream and
// are each checked cycle by cycle against an ownership-level reference model.
module tb_shared_net_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [3:0] rel = 4'b0;
  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  shared_net_arbiter_if #(.N_REQ(4)) if_a ();
  shared_net_arbiter_if #(.N_REQ(4)) if_b ();
  shared_net_arbiter_if #(.N_REQ(4)) if_c ();

  assign if_a.req = req;
  assign if_a.rel = rel;
  assign if_b.req = req;
  assign if_b.rel = rel;
  assign if_c.req = req;
  assign if_c.rel = rel;

  shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(4), .TURN_CYC(1))
    u_a (.clk(clk), .rst_n(rst_n), .arb_if(if_a));
  shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(3), .TURN_CYC(0))
    u_b (.clk(clk), .rst_n(rst_n), .arb_if(if_b));
  shared_net_arbiter #(.N_REQ(4), .MAX_HOLD(0), .TURN_CYC(2))
    u_c (.clk(clk), .rst_n(rst_n), .arb_if(if_c));

  // phase: 0 = net free, 1 = owned, 2 = turnaround gap
  typedef struct {
    int phase;
    int owner;
    int last;
    int ptr;
    int held;
    int gap;
    bit to;
  } mdl_t;

  typedef struct {
    int         cyc;
    logic [8:0] v;
  } exp_t;

  mdl_t ma, mb, mc;
  exp_t qa[$], qb[$], qc[$];

  function automatic int pick(input bit [3:0] rq, input int from);
    for (int k = 0; k < 4; k++) begin
      if (rq[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  function automatic mdl_t grant(input mdl_t s, input int w);
    mdl_t n = s;
    n.phase = 1;
    n.owner = w;
    n.last  = w;
    n.held  = 1;
    return n;
  endfunction

  function automatic mdl_t step(input mdl_t s, input bit run, input bit [3:0] rq,
                                input bit [3:0] rl, input int mh, input int tc);
    mdl_t n;
    int   w;
    bit   drop, quit, lim;
    n = s;
    n.to = 1'b0;
    if (!run) begin
      n = '{0, 0, 0, 0, 0, 0, 1'b0};
      return n;
    end
    case (s.phase)
      0: begin
        w = pick(rq, s.ptr);
        if (w >= 0) n = grant(n, w);
      end
      1: begin
        drop = !rq[s.owner];
        quit = rl[s.owner];
        lim  = (mh != 0) && (s.held >= mh);
        if (drop || quit || lim) begin
          n.to    = lim && !drop && !quit;
          n.ptr   = (s.owner + 1) % 4;
          n.phase = 0;
          if (tc > 0) begin
            n.phase = 2;
            n.gap   = tc;
          end else begin
            w = pick(rq, n.ptr);
            if (w >= 0) n = grant(n, w);
          end
        end else begin
          n.held = s.held + 1;
        end
      end
      default: begin
        if (s.gap <= 1) begin
          n.phase = 0;
          w = pick(rq, s.ptr);
          if (w >= 0) n = grant(n, w);
        end else begin
          n.gap = s.gap - 1;
        end
      end
    endcase
    return n;
  endfunction

  // {drv_en, owner_id, turn, timeout, owner_vld}
  function automatic logic [8:0] outv(input mdl_t s);
    logic [3:0] d;
    logic [1:0] id;
    d  = (s.phase == 1) ? (4'b0001 << s.owner) : 4'b0000;
    id = 2'(s.last);
    return {d, id, (s.phase == 2), s.to, (s.phase == 1)};
  endfunction

  task automatic drive(input bit r, input bit [3:0] rq, input bit [3:0] rl);
    @(posedge clk);
    #1;
    rst_n = r;
    req   = rq;
    rel   = rl;
    ma = step(ma, r, rq, rl, 4, 1);
    mb = step(mb, r, rq, rl, 3, 0);
    mc = step(mc, r, rq, rl, 0, 2);
    qa.push_back('{cyc + 1, outv(ma)});
    qb.push_back('{cyc + 1, outv(mb)});
    qc.push_back('{cyc + 1, outv(mc)});
  endtask

  task automatic check(input string nm, input logic [8:0] act, input logic [8:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got {drv,id,turn,to,vld}=%b want=%b", nm, cyc, act, exp_v);
    end
  endtask

  task automatic check_inv(input string nm, input logic [3:0] d, input logic t);
    vectors++;
    if (!$onehot0(d) || (t && (d != 4'b0))) begin
      miscompares++;
      $display("FAIL %s_onehot cyc=%0d got drv_en=%b turn=%b want onehot0 and no drive in turn",
               nm, cyc, d, t);
    end
  endtask

  // Monitor: pops the entry scheduled for this cycle and compares it.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (qa.size() > 0 && qa[0].cyc < cyc) void'(qa.pop_front());
      while (qb.size() > 0 && qb[0].cyc < cyc) void'(qb.pop_front());
      while (qc.size() > 0 && qc[0].cyc < cyc) void'(qc.pop_front());
      if (qa.size() > 0 && qa[0].cyc == cyc) begin
        e = qa.pop_front();
        check("u_a", {if_a.drv_en, if_a.owner_id, if_a.turn, if_a.timeout, if_a.owner_vld}, e.v);
        check_inv("u_a", if_a.drv_en, if_a.turn);
      end
      if (qb.size() > 0 && qb[0].cyc == cyc) begin
        e = qb.pop_front();
        check("u_b", {if_b.drv_en, if_b.owner_id, if_b.turn, if_b.timeout, if_b.owner_vld}, e.v);
        check_inv("u_b", if_b.drv_en, if_b.turn);
      end
      if (qc.size() > 0 && qc[0].cyc == cyc) begin
        e = qc.pop_front();
        check("u_c", {if_c.drv_en, if_c.owner_id, if_c.turn, if_c.timeout, if_c.owner_vld}, e.v);
        check_inv("u_c", if_c.drv_en, if_c.turn);
      end
    end
  end

  initial begin
    bit [3:0] cur;
    bit [3:0] rl;
    bit       r;
    ma = '{0, 0, 0, 0, 0, 0, 1'b0};
    mb = ma;
    mc = ma;

    $display("[%0t] txn reset with all requests high", $time);
    repeat (3) drive(1'b0, 4'b1111, 4'b0000);
    repeat (2) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn single requester 0", $time);
    repeat (5) drive(1'b1, 4'b0001, 4'b0000);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn all requesting, fairness and hold limit", $time);
    repeat (30) drive(1'b1, 4'b1111, 4'b0000);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn foreign then own release", $time);
    repeat (3) drive(1'b1, 4'b0100, 4'b0000);
    drive(1'b1, 4'b0100, 4'b0001);
    drive(1'b1, 4'b0100, 4'b0000);
    drive(1'b1, 4'b0100, 4'b0100);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn reset during ownership", $time);
    repeat (3) drive(1'b1, 4'b0010, 4'b0000);
    drive(1'b0, 4'b0010, 4'b0000);
    repeat (4) drive(1'b1, 4'b0011, 4'b0000);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn handover after request drop", $time);
    drive(1'b0, 4'b0000, 4'b0000);
    repeat (3) drive(1'b1, 4'b0110, 4'b0000);
    repeat (3) drive(1'b1, 4'b0100, 4'b0000);
    repeat (3) drive(1'b1, 4'b0000, 4'b0000);

    $display("[%0t] txn randomized traffic, 600 cycles", $time);
    cur = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) cur[b] = ~cur[b];
      end
      rl = ($urandom_range(9) == 0) ? (4'b0001 << $urandom_range(3)) : 4'b0000;
      r  = ($urandom_range(149) != 0);
      drive(r, cur, rl);
    end
    repeat (2) drive(1'b1, 4'b0000, 4'b0000);

    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
